// File: rtl/ebike_pkg.sv
// Shared types and constants for the e-bike cadence path.
// Holds the cadence FSM encoding, counter widths and a saturating-increment helper.
package ebike_pkg;

  typedef enum logic {CAD_IDLE, CAD_RUN} cad_state_t;

  localparam int CAD_PRE_W      = 10;
  localparam int CAD_PRE_FAST_W = 4;
  localparam int CAD_PER_W      = 8;

  // Adds a single bit to a period-width value, holding at all-ones.
  function automatic logic [CAD_PER_W-1:0] sat_inc(
    input logic [CAD_PER_W-1:0] val,
    input logic                 inc
  );
    if (&val) begin
      return val;
    end
    return val + {{(CAD_PER_W-1){1'b0}}, inc};
  endfunction

endpackage

// File: rtl/cadence_avg4.sv
// Running mean of the last four cadence periods, with the new sample included combinationally.
// Three stored samples plus the incoming one form the four-sample window; preload fills the window.
module cadence_avg4
  import ebike_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CAD_PER_W-1:0] sample_i,
  input  logic                 load_i,
  input  logic                 preload_i,
  output logic [CAD_PER_W-1:0] avg_o
);

  localparam int HIST_D = 3;

  logic [CAD_PER_W-1:0] hist_q [HIST_D];
  logic [CAD_PER_W+1:0] sum;

  always_comb begin
    if (preload_i) begin
      sum = {sample_i, 2'b00};
    end else begin
      sum = {2'b00, sample_i} + {2'b00, hist_q[0]} + {2'b00, hist_q[1]} + {2'b00, hist_q[2]};
    end
    avg_o = sum[CAD_PER_W+1:2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HIST_D; i++) begin
        hist_q[i] <= '0;
      end
    end else if (load_i) begin
      if (preload_i) begin
        for (int i = 0; i < HIST_D; i++) begin
          hist_q[i] <= sample_i;
        end
      end else begin
        hist_q[0] <= sample_i;
        hist_q[1] <= hist_q[0];
        hist_q[2] <= hist_q[1];
      end
    end
  end

endmodule

// File: rtl/cadence_meas.sv
// Pedal-cadence period measurement and pedaling/not-pedaling sequencing.
// Optional macro CADENCE_AVG_EN publishes a 4-sample running mean instead of the raw period.
module cadence_meas
  import ebike_pkg::*;
#(
  parameter bit                   FAST_SIM    = 1'b0,
  parameter logic [CAD_PER_W-1:0] STALL_TICKS = 8'd255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cadence_filt,
  output logic                 cadence_rise,
  output logic                 per_vld,
  output logic [CAD_PER_W-1:0] cadence_per,
  output logic                 not_pedaling
);

  // per_vld is a one-cycle strobe with no ready: the consumer must take cadence_per
  // in that cycle; cadence_per then holds until the next strobe or a stall.

  cad_state_t           state_q, state_d;
  logic                 cad_ff_q;
  logic [CAD_PRE_W-1:0] pre_q, pre_d;
  logic [CAD_PER_W-1:0] tick_cnt_q, tick_cnt_d;
  logic                 rise_q;
  logic                 per_vld_q, per_vld_d;
  logic [CAD_PER_W-1:0] per_q, per_d;
  logic                 rise;
  logic                 tick;
  logic [CAD_PER_W-1:0] meas;
  logic [CAD_PER_W-1:0] per_sample;

  assign rise = cadence_filt & ~cad_ff_q;

  always_comb begin
    if (FAST_SIM) begin
      tick = &pre_q[CAD_PRE_FAST_W-1:0];
    end else begin
      tick = &pre_q;
    end
  end

  // A tick landing on the edge cycle belongs to the period that is ending.
  assign meas       = sat_inc(tick_cnt_q, tick);
  assign pre_d      = rise ? '0 : pre_q + {{(CAD_PRE_W-1){1'b0}}, 1'b1};
  assign tick_cnt_d = rise ? '0 : sat_inc(tick_cnt_q, tick);

`ifdef CADENCE_AVG_EN
  logic first_q;
  logic avg_load;
  logic [CAD_PER_W-1:0] avg;

  assign avg_load = (state_q == CAD_RUN) && rise;

  cadence_avg4 u_avg (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample_i  (meas),
    .load_i    (avg_load),
    .preload_i (first_q),
    .avg_o     (avg)
  );

  // Marks that the next valid period is the first since leaving idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q <= 1'b0;
    end else if ((state_q == CAD_IDLE) && rise) begin
      first_q <= 1'b1;
    end else if (avg_load) begin
      first_q <= 1'b0;
    end
  end

  assign per_sample = avg;
`else
  assign per_sample = meas;
`endif

  always_comb begin
    state_d   = state_q;
    per_vld_d = 1'b0;
    per_d     = per_q;
    case (state_q)
      CAD_IDLE: begin
        if (rise) begin
          state_d = CAD_RUN;
        end
      end
      CAD_RUN: begin
        // An edge on the stall cycle still counts as a period.
        if (rise) begin
          per_vld_d = 1'b1;
          per_d     = per_sample;
        end else if (tick_cnt_q == STALL_TICKS) begin
          state_d = CAD_IDLE;
          per_d   = '1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cad_ff_q   <= 1'b0;
      pre_q      <= '0;
      tick_cnt_q <= '0;
      state_q    <= CAD_IDLE;
      rise_q     <= 1'b0;
      per_vld_q  <= 1'b0;
      per_q      <= '1;
    end else begin
      cad_ff_q   <= cadence_filt;
      pre_q      <= pre_d;
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      rise_q     <= rise;
      per_vld_q  <= per_vld_d;
      per_q      <= per_d;
    end
  end

  assign cadence_rise = rise_q;
  assign per_vld      = per_vld_q;
  assign cadence_per  = per_q;
  assign not_pedaling = (state_q == CAD_IDLE);

endmodule

// File: tb/tb_cadence_meas.sv
// Self-checking bench for cadence_meas (FAST_SIM, 16 clk per tick, stall after 255 ticks).
// Expectations come from rise-to-rise gaps measured in clock edges, not from DUT internals.
module tb_cadence_meas;

  localparam int TICK    = 16;
  localparam int STALL   = 255;
  localparam int STALL_D = STALL * TICK + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cadence_filt = 1'b0;
  logic       cadence_rise;
  logic       per_vld;
  logic [7:0] cadence_per;
  logic       not_pedaling;

  cadence_meas #(
    .FAST_SIM    (1'b1),
    .STALL_TICKS (8'd255)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cadence_filt (cadence_filt),
    .cadence_rise (cadence_rise),
    .per_vld      (per_vld),
    .cadence_per  (cadence_per),
    .not_pedaling (not_pedaling)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // reference model state
  bit         ped = 1'b0;
  bit         first = 1'b0;
  int         last_e = 0;
  logic [7:0] exp_per = 8'hFF;
  int         hist[$];
  logic [7:0] exp_q[$];
  int         n_chk = 0;
  int         n_pass = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // One quiet cycle: applies the stall rule when the gap passes the stall limit.
  task automatic idle_step();
    @(negedge clk);
    if (ped && (edge_n - last_e) >= STALL_D) begin
      ped     = 1'b0;
      exp_per = 8'hFF;
    end
    chk("not_ped", not_pedaling, 8'(!ped));
    chk("per_hold", cadence_per, exp_per);
    chk("no_vld", per_vld, 8'd0);
    chk("no_rise", cadence_rise, 8'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) idle_step();
  endtask

  // Drives a rising edge sampled exactly gap clock edges after the previous one.
  task automatic rise_after(input int gap);
    int  m;
    int  sum;
    bit  ev;
    while (edge_n - last_e < gap - 1) idle_step();
    cadence_filt = 1'b1;
    @(negedge clk);
    cadence_filt = 1'b0;
    ev = 1'b0;
    if (ped) begin
      m = (edge_n - last_e) / TICK;
      if (m > 255) m = 255;
`ifdef CADENCE_AVG_EN
      if (first) begin
        hist  = {m, m, m, m};
        first = 1'b0;
      end else begin
        hist.push_front(m);
        void'(hist.pop_back());
      end
      sum = hist[0] + hist[1] + hist[2] + hist[3];
      exp_q.push_back(8'(sum / 4));
`else
      sum = m;
      exp_q.push_back(8'(sum));
`endif
      exp_per = exp_q.pop_front();
      ev = 1'b1;
    end else begin
      ped   = 1'b1;
      first = 1'b1;
    end
    last_e = edge_n;
    chk("rise", cadence_rise, 8'd1);
    chk("np_run", not_pedaling, 8'd0);
    chk("vld", per_vld, 8'(ev));
    chk("per", cadence_per, exp_per);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_np", not_pedaling, 8'd1);
    chk("rst_per", cadence_per, 8'hFF);
    chk("rst_vld", per_vld, 8'd0);
    chk("rst_rise", cadence_rise, 8'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    ped     = 1'b0;
    exp_per = 8'hFF;
    last_e  = edge_n;
  endtask

  initial begin
    int gap;
    repeat (3) @(negedge clk);
    chk("init_np", not_pedaling, 8'd1);
    chk("init_per", cadence_per, 8'hFF);
    chk("init_vld", per_vld, 8'd0);
    chk("init_rise", cadence_rise, 8'd0);
    rst_n  = 1'b1;
    last_e = edge_n;

    // long idle, then steady 160 clk pedaling
    idle_cycles(5000);
    rise_after(3);
    for (int i = 0; i < 5; i++) rise_after(160);

    // slow down to 320 clk (raw 20, or averaged 12/15/17/20)
    for (int i = 0; i < 5; i++) rise_after(320);

    // stall, then re-entry needs two edges
    rise_after(160);
    rise_after(4200);
    rise_after(160);
    rise_after(160);

    // stall boundary: last valid gaps, then first stalling gap
    rise_after(4080);
    rise_after(4081);
    rise_after(4082);
    rise_after(160);

    // reset in the middle of a running period
    rise_after(160);
    idle_cycles(50);
    pulse_reset();
    rise_after(100);
    rise_after(100);

    // randomized gaps, occasionally straddling the stall limit
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 7) == 0) gap = $urandom_range(4075, 4090);
      else gap = $urandom_range(3, 700);
      rise_after(gap);
    end
    idle_cycles(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
